// File: rtl/fpga9685_pkg.sv
// Shared constants and types for the fpga9685 register path.
package fpga9685_pkg;

  localparam logic [7:0] LED_BASE_ADDR     = 8'h06;
  localparam logic [7:0] ALL_LED_BASE_ADDR = 8'hFA;
  localparam int         NUM_LEDS          = 16;
  localparam int         BYTES_PER_LED     = 4;

  typedef logic [7:0] reg_addr_t;

endpackage

// File: rtl/lowest_set_pick16.sv
// Combinational lowest-set-bit encoder over 16 bits: index of the lowest 1 and a valid flag.
module lowest_set_pick16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = 4'd0;
    valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      idx   = vec[i] ? 4'(i) : idx;
      valid = valid | vec[i];
    end
  end

endmodule

// File: rtl/all_led_write_scheduler.sv
// Owns the register write port: host writes pass through, ALL_LED writes fan out into per-LED writes.
// Optional macro ALL_LED_OVERRIDE_EN: a host LED write cancels that LED's pending broadcast write.
module all_led_write_scheduler
  import fpga9685_pkg::*;
#(
  parameter reg_addr_t LED_BASE     = LED_BASE_ADDR,
  parameter reg_addr_t ALL_LED_BASE = ALL_LED_BASE_ADDR
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_id_i,
  input  logic [7:0] req_value_i,
  input  logic       req_en_i,
  output logic [7:0] write_register_id_o,
  output logic [7:0] write_register_value_o,
  output logic       write_enable_o,
  output logic       busy_o
);

  logic [BYTES_PER_LED-1:0][NUM_LEDS-1:0] todo_r;
  logic [BYTES_PER_LED-1:0][7:0]          bval_r;

  logic [3:0] byte_nz_s;
  logic [3:0] byte_idx_s;
  logic       byte_valid_s;
  logic [1:0] byte_sel_s;
  logic [3:0] led_idx_s;
  logic       led_valid_s;
  logic       bg_go_s;
  reg_addr_t  bg_id_s;
  logic       is_all_s;
  logic [1:0] all_byte_s;
`ifdef ALL_LED_OVERRIDE_EN
  logic       is_led_s;
  logic [5:0] led_lo_s;
`endif

  // Which broadcast bytes still have LEDs owed a write.
  always_comb begin
    for (int b = 0; b < BYTES_PER_LED; b++) begin
      byte_nz_s[b] = |todo_r[b];
    end
  end

  lowest_set_pick16 u_byte_pick (
    .vec   ({12'd0, byte_nz_s}),
    .idx   (byte_idx_s),
    .valid (byte_valid_s)
  );

  assign byte_sel_s = byte_idx_s[1:0];

  lowest_set_pick16 u_led_pick (
    .vec   (todo_r[byte_sel_s]),
    .idx   (led_idx_s),
    .valid (led_valid_s)
  );

  // Range checks use a 9-bit compare so a base near 8'hFF cannot wrap into low addresses.
  always_comb begin
    is_all_s   = ({1'b0, req_id_i} >= {1'b0, ALL_LED_BASE}) &&
                 ({1'b0, req_id_i} <= ({1'b0, ALL_LED_BASE} + 9'd3));
    all_byte_s = 2'(req_id_i - ALL_LED_BASE);
`ifdef ALL_LED_OVERRIDE_EN
    is_led_s   = ({1'b0, req_id_i} >= {1'b0, LED_BASE}) &&
                 ({1'b0, req_id_i} <= ({1'b0, LED_BASE} + 9'd63));
    led_lo_s   = 6'(req_id_i - LED_BASE);
`endif
    bg_go_s    = byte_valid_s && led_valid_s && (byte_idx_s[3:2] == 2'b00);
    bg_id_s    = LED_BASE + {2'b00, led_idx_s, 2'b00} + {6'd0, byte_sel_s};
  end

  assign busy_o = |todo_r;

  // Port arbitration: host write first, then one background write, else idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      todo_r                 <= '0;
      bval_r                 <= '0;
      write_register_id_o    <= 8'h00;
      write_register_value_o <= 8'h00;
      write_enable_o         <= 1'b0;
    end else if (req_en_i) begin
      write_register_id_o    <= req_id_i;
      write_register_value_o <= req_value_i;
      write_enable_o         <= 1'b1;
      if (is_all_s) begin
        todo_r[all_byte_s] <= 16'hFFFF;
        bval_r[all_byte_s] <= req_value_i;
      end
`ifdef ALL_LED_OVERRIDE_EN
      if (is_led_s) begin
        todo_r[led_lo_s[1:0]][led_lo_s[5:2]] <= 1'b0;
      end
`endif
    end else if (bg_go_s) begin
      write_register_id_o               <= bg_id_s;
      write_register_value_o            <= bval_r[byte_sel_s];
      write_enable_o                    <= 1'b1;
      todo_r[byte_sel_s][led_idx_s]     <= 1'b0;
    end else begin
      write_enable_o <= 1'b0;
    end
  end

endmodule
